// File: rtl/dm_cache_refill_ctrl.sv
// Direct-mapped read cache with multi-word lines and a burst line-refill FSM.
// Hits answer in one cycle; misses fetch the whole line before answering.
module dm_cache_refill_ctrl #(
   parameter int WORD_W   = 32,
   parameter int ADDR_W   = 15,
   parameter int INDEX_W  = 10,
   parameter int OFFSET_W = 2,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic              cpu_ready,
   output logic [WORD_W-1:0] cpu_rdata,
   input  logic              inv,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [WORD_W-1:0] mem_rdata,
   input  logic              mem_valid,
   output logic              busy,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);

   localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
   localparam int LINES = 2 ** INDEX_W;
   localparam int WORDS = LINES * (2 ** OFFSET_W);

   typedef enum logic [1:0] {
      IDLE,
      REFILL,
      DONE
   } state_e;

   state_e state_q, state_d;

   logic [LINES-1:0]    valid_q;
   logic [TAG_W-1:0]    tag_ram [LINES];
   logic [WORD_W-1:0]   data_ram [WORDS];

   logic [TAG_W-1:0]    tag_q;
   logic [INDEX_W-1:0]  idx_q;
   logic [OFFSET_W-1:0] off_q;
   logic [OFFSET_W-1:0] beat_q;
   logic                cpu_ready_q;
   logic                mem_req_q;
   logic                inv_pend_q;
   logic [WORD_W-1:0]   rdata_q;
   logic [CNT_W-1:0]    hit_q;
   logic [CNT_W-1:0]    miss_q;

   logic [TAG_W-1:0]    a_tag;
   logic [INDEX_W-1:0]  a_idx;
   logic [OFFSET_W-1:0] a_off;

   logic hit, miss, fire, last, inv_clr;

   assign a_tag = cpu_addr[ADDR_W-1 -: TAG_W];
   assign a_idx = cpu_addr[OFFSET_W +: INDEX_W];
   assign a_off = cpu_addr[OFFSET_W-1:0];

   always_comb begin
      state_d = state_q;
      hit     = 1'b0;
      miss    = 1'b0;
      fire    = 1'b0;
      last    = 1'b0;
      inv_clr = 1'b0;
      unique case (state_q)
         IDLE: begin
            // a fresh or deferred invalidate blocks acceptance this cycle
            if (inv || inv_pend_q) begin
               inv_clr = 1'b1;
            end else if (cpu_req && !cpu_ready_q) begin
               if (valid_q[a_idx] && tag_ram[a_idx] == a_tag) begin
                  hit = 1'b1;
               end else begin
                  miss    = 1'b1;
                  state_d = REFILL;
               end
            end
         end
         REFILL: begin
            if (mem_valid) begin
               fire = 1'b1;
               if (beat_q == '1) begin
                  last    = 1'b1;
                  state_d = DONE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q     <= '0;
         tag_q       <= '0;
         idx_q       <= '0;
         off_q       <= '0;
         beat_q      <= '0;
         cpu_ready_q <= 1'b0;
         mem_req_q   <= 1'b0;
         inv_pend_q  <= 1'b0;
         rdata_q     <= '0;
         hit_q       <= '0;
         miss_q      <= '0;
      end else begin
         cpu_ready_q <= hit | last;
         if (inv_clr) valid_q <= '0;
         if (inv && state_q != IDLE) inv_pend_q <= 1'b1;
         else if (inv_clr)           inv_pend_q <= 1'b0;
         if (hit) begin
            rdata_q <= data_ram[{a_idx, a_off}];
            if (!(&hit_q)) hit_q <= hit_q + CNT_W'(1);
         end
         if (miss) begin
            if (!(&miss_q)) miss_q <= miss_q + CNT_W'(1);
            valid_q[a_idx] <= 1'b0;
            tag_q          <= a_tag;
            idx_q          <= a_idx;
            off_q          <= a_off;
            beat_q         <= '0;
            mem_req_q      <= 1'b1;
         end
         if (fire) begin
            if (beat_q == off_q) rdata_q <= mem_rdata;
            beat_q <= beat_q + OFFSET_W'(1);
         end
         if (last) begin
            valid_q[idx_q] <= 1'b1;
            mem_req_q      <= 1'b0;
         end
      end
   end

   // line storage carries no reset; validity alone guards it
   always_ff @(posedge clk) begin
      if (fire) data_ram[{idx_q, beat_q}] <= mem_rdata;
      if (last) tag_ram[idx_q] <= tag_q;
   end

   assign cpu_ready = cpu_ready_q;
   assign cpu_rdata = rdata_q;
   assign mem_req   = mem_req_q;
   assign mem_addr  = {tag_q, idx_q, beat_q};
   assign busy      = (state_q != IDLE);
   assign hit_cnt   = hit_q;
   assign miss_cnt  = miss_q;

endmodule

// File: tb/tb_dm_cache_refill_ctrl.sv
// Randomised bench for dm_cache_refill_ctrl against a line-level cache model.
// A second instance with 2-bit counters shares all inputs to exercise saturation.
module tb_dm_cache_refill_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req;
   logic [14:0] cpu_addr;
   logic        cpu_ready;
   logic [31:0] cpu_rdata;
   logic        inv;
   logic        mem_req;
   logic [14:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_valid;
   logic        busy;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   logic        s_ready;
   logic [31:0] s_rdata;
   logic        s_mem_req;
   logic [14:0] s_mem_addr;
   logic        s_busy;
   logic [1:0]  s_hit;
   logic [1:0]  s_miss;

   int checks = 0;
   int failures = 0;

   bit         mv [1024];
   logic [2:0] mt [1024];
   int         hits;
   int         misses;
   logic [31:0] salt;

   always #5 clk = ~clk;

   dm_cache_refill_ctrl dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr),
      .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .inv(inv),
      .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .mem_valid(mem_valid),
      .busy(busy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   dm_cache_refill_ctrl #(.CNT_W(2)) u_sat (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_addr(cpu_addr),
      .cpu_ready(s_ready), .cpu_rdata(s_rdata),
      .inv(inv),
      .mem_req(s_mem_req), .mem_addr(s_mem_addr),
      .mem_rdata(mem_rdata), .mem_valid(mem_valid),
      .busy(s_busy), .hit_cnt(s_hit), .miss_cnt(s_miss)
   );

   function automatic logic [31:0] memfn(input logic [14:0] a);
      logic [31:0] w;
      w = {17'h0, a} * 32'h9E3779B1;
      return w ^ salt;
   endfunction

   function automatic int sat3(input int n);
      return (n > 3) ? 3 : n;
   endfunction

   function automatic bit model_hit(input logic [14:0] a);
      return mv[a[11:2]] && (mt[a[11:2]] == a[14:12]);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 1024; i++) mv[i] = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cpu_req = 1'b0;
      cpu_addr = '0;
      inv = 1'b0;
      mem_valid = 1'b0;
      mem_rdata = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_clear();
      hits = 0;
      misses = 0;
   endtask

   task automatic check_counters(input string nm);
      checks++;
      if (hit_cnt !== 16'(hits) || miss_cnt !== 16'(misses)) begin
         failures++;
         $display("FAIL %s cnt: hit=%0d miss=%0d want %0d/%0d",
                  nm, hit_cnt, miss_cnt, hits, misses);
      end
      checks++;
      if (s_hit !== 2'(sat3(hits)) || s_miss !== 2'(sat3(misses))) begin
         failures++;
         $display("FAIL %s satcnt: hit=%0d miss=%0d want %0d/%0d",
                  nm, s_hit, s_miss, sat3(hits), sat3(misses));
      end
   endtask

   // gap<0 picks a random 0..3 idle cycles before each beat
   task automatic do_read(input logic [14:0] a, input int gap,
                          input int inv_beat, input string nm);
      int  beats = 0;
      int  wait_c;
      int  cyc = 0;
      bit  done = 0;
      bit  missed = 0;
      bit  inv_sent = 0;
      bit  exp_hit;
      int  lat = 0;
      logic [31:0] rd = '0;
      exp_hit = model_hit(a);
      @(negedge clk);
      cpu_req = 1'b1;
      cpu_addr = a;
      mem_valid = 1'b0;
      wait_c = (gap < 0) ? $urandom_range(0, 3) : gap;
      while (!done && cyc < 200) begin
         @(negedge clk);
         cyc++;
         inv = 1'b0;
         mem_valid = 1'b0;
         mem_rdata = $urandom;
         if (cpu_ready) begin
            done = 1;
            lat = cyc;
            rd = cpu_rdata;
            cpu_req = 1'b0;
            checks++;
            if (s_ready !== 1'b1 || s_rdata !== cpu_rdata) begin
               failures++;
               $display("FAIL %s sat_resp: rdy=%b rd=%h want 1 %h",
                        nm, s_ready, s_rdata, cpu_rdata);
            end
         end else if (mem_req) begin
            missed = 1;
            checks++;
            if (mem_addr !== {a[14:2], 2'(beats)} || s_mem_addr !== mem_addr) begin
               failures++;
               $display("FAIL %s mem_addr: got %h want %h",
                        nm, mem_addr, {a[14:2], 2'(beats)});
            end
            checks++;
            if (busy !== 1'b1) begin
               failures++;
               $display("FAIL %s busy: got %b want 1", nm, busy);
            end
            if (inv_beat == beats && !inv_sent) begin
               inv = 1'b1;
               inv_sent = 1;
            end
            if (wait_c == 0) begin
               mem_valid = 1'b1;
               mem_rdata = memfn({a[14:2], 2'(beats)});
               beats++;
               wait_c = (gap < 0) ? $urandom_range(0, 3) : gap;
            end else begin
               wait_c--;
            end
         end
      end
      inv = 1'b0;
      mem_valid = 1'b0;
      cpu_req = 1'b0;
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL %s timeout: no cpu_ready within 200 cycles", nm);
         return;
      end
      if (rd !== memfn(a)) begin
         failures++;
         $display("FAIL %s rdata: got %h want %h", nm, rd, memfn(a));
      end
      checks++;
      if (missed !== !exp_hit) begin
         failures++;
         $display("FAIL %s hitmiss: missed=%b want %b", nm, missed, !exp_hit);
      end
      if (exp_hit) begin
         hits++;
         checks++;
         if (lat != 1) begin
            failures++;
            $display("FAIL %s hit_latency: got %0d want 1", nm, lat);
         end
      end else begin
         misses++;
         mv[a[11:2]] = 1'b1;
         mt[a[11:2]] = a[14:12];
         checks++;
         if (beats != 4) begin
            failures++;
            $display("FAIL %s beats: got %0d want 4", nm, beats);
         end
      end
      if (inv_sent) model_clear();
      check_counters(nm);
   endtask

   task automatic pulse_inv();
      @(negedge clk);
      inv = 1'b1;
      @(negedge clk);
      inv = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (cpu_ready !== 1'b0 || cpu_rdata !== '0 || mem_req !== 1'b0 ||
          mem_addr !== '0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL reset: rdy=%b rd=%h req=%b addr=%h busy=%b want zeros",
                  cpu_ready, cpu_rdata, mem_req, mem_addr, busy);
      end
      // stray mem_valid while idle must be ignored
      mem_valid = 1'b1;
      mem_rdata = 32'hDEAD_BEEF;
      repeat (3) @(negedge clk);
      mem_valid = 1'b0;
      check_counters("reset");
      checks++;
      if (busy !== 1'b0 || mem_req !== 1'b0) begin
         failures++;
         $display("FAIL idle_valid: busy=%b req=%b want 0 0", busy, mem_req);
      end
   endtask

   task automatic test_directed();
      do_read(15'h0042, 0, -1, "t1_miss");
      do_read(15'h0041, 0, -1, "t2_hit");
      do_read(15'h1040, 0, -1, "t3_newtag");
      do_read(15'h0040, 0, -1, "t3_evicted");
      do_read(15'h0123, 3, -1, "t4_gaps");
   endtask

   task automatic test_inv();
      do_read(15'h0080, 1, 2, "t5_inv_refill");
      do_read(15'h0080, 0, -1, "t5_reread");
      do_read(15'h0040, 0, -1, "t5_other");
      do_read(15'h0041, 0, -1, "inv_pre_hit");
      @(negedge clk);
      inv = 1'b1;
      cpu_req = 1'b1;
      cpu_addr = 15'h0041;
      @(negedge clk);
      inv = 1'b0;
      model_clear();
      checks++;
      if (cpu_ready !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL inv_priority: rdy=%b busy=%b want 0 0", cpu_ready, busy);
      end
      do_read(15'h0041, 0, -1, "inv_after");
   endtask

   task automatic test_reset_mid_refill();
      int beats = 0;
      int cyc = 0;
      @(negedge clk);
      cpu_req = 1'b1;
      cpu_addr = 15'h0300;
      while (cyc < 50 && !(mem_req && beats == 2)) begin
         @(negedge clk);
         cyc++;
         mem_valid = 1'b0;
         if (mem_req && beats < 2) begin
            mem_valid = 1'b1;
            mem_rdata = memfn({13'h00C0, 2'(beats)});
            beats++;
         end
      end
      mem_valid = 1'b0;
      checks++;
      if (!(mem_req && beats == 2)) begin
         failures++;
         $display("FAIL t6_setup: refill did not reach beat 2 (req=%b)", mem_req);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (mem_req !== 1'b0 || busy !== 1'b0 || cpu_ready !== 1'b0) begin
         failures++;
         $display("FAIL t6_async: req=%b busy=%b rdy=%b want 0 0 0",
                  mem_req, busy, cpu_ready);
      end
      do_reset();
      check_counters("t6_cnt");
      do_read(15'h0300, 0, -1, "t6_reread");
   endtask

   task automatic test_back_to_back();
      int n = 0;
      do_reset();
      do_read(15'h0200, 0, -1, "t7_fill");
      @(negedge clk);
      cpu_req = 1'b1;
      cpu_addr = 15'h0202;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (cpu_ready) begin
            n++;
            checks++;
            if (cpu_rdata !== memfn(15'h0202)) begin
               failures++;
               $display("FAIL b2b_rdata: got %h want %h", cpu_rdata, memfn(15'h0202));
            end
         end
         checks++;
         if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL b2b_memreq: got %b want 0", mem_req);
         end
      end
      cpu_req = 1'b0;
      hits += 5;
      checks++;
      if (n != 5) begin
         failures++;
         $display("FAIL b2b_rate: got %0d hits want 5", n);
      end
      check_counters("t7_sat");
   endtask

   task automatic test_random();
      logic [14:0] a;
      logic [9:0]  idx;
      int          ib;
      for (int k = 0; k < 40; k++) begin
         case ($urandom_range(0, 2))
            0:       idx = 10'h010;
            1:       idx = 10'h011;
            default: idx = 10'h3FF;
         endcase
         a = {3'($urandom_range(0, 2)), idx, 2'($urandom)};
         if ($urandom_range(0, 7) == 0) pulse_inv();
         ib = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 3) : -1;
         do_read(a, -1, ib, "random");
      end
   endtask

   initial begin
      salt = $urandom;
      test_reset();
      test_directed();
      test_inv();
      test_reset_mid_refill();
      test_back_to_back();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
